audio_mix_nch: RTL and testbench
================================

Name: audio_mix_nch

Overview:
- Parametrised N-channel audio mixer; successor to the fixed two-source adder that fed the master playback buffer.
- On each sample tick it snapshots all channel samples and scales each by its own volume, honouring a per-channel enable mask.
- It then accumulates the channels, applies master volume, saturates the result to SAMPLE_BITS, and writes one word into the playback ring buffer at a lagged address behind the player's read index.
- Single clock domain (mclk side); one multiplier time-shared across channels.

Parameters:
- NUM_CH, 4, number of mixed source channels (>=1)
- SAMPLE_BITS, 16, signed sample width
- VOLUME_BITS, 8, unsigned volume width; gain = vol / 2^VOLUME_BITS
- BUF_LEN, 256, playback ring-buffer depth (power of two)
- LAG, 1, write distance behind rd_index (1..BUF_LEN-1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sample_tick  in  1  one-cycle strobe per audio frame, synchronous to clk
- refresh  in  1  mixing enable; ticks ignored while low
- ch_sample  in  NUM_CH*SAMPLE_BITS  packed signed samples, ch0 in LSBs
- ch_volume  in  NUM_CH*VOLUME_BITS  packed unsigned per-channel volumes
- ch_enable  in  NUM_CH  per-channel enable; a disabled channel contributes 0
- master_volume  in  VOLUME_BITS  unsigned master gain
- rd_index  in  $clog2(BUF_LEN)  player's current read index
- wr_en  out  1  one-cycle write strobe to the ring buffer
- wr_addr  out  $clog2(BUF_LEN)  write address
- wr_data  out  SAMPLE_BITS  mixed, saturated sample
- busy  out  1  mix in progress
- clip  out  1  saturation occurred on the last written sample
- overrun  out  1  one-cycle pulse when a tick is dropped while busy

Behaviour:
- Reset: state IDLE, accumulator 0; all outputs 0 (wr_en, wr_addr, wr_data, busy, clip, overrun).
- Tick acceptance:
  - A tick is accepted when state is IDLE, refresh=1 and rst=0.
  - On acceptance, register ch_sample, ch_volume, ch_enable and master_volume.
  - Latch wr_addr_next = (rd_index - LAG) mod BUF_LEN, modular wrap.
  - Inputs may change after the tick without affecting the result.
- FSM:
  - IDLE -> ACCUM on accepted tick.
  - ACCUM: one channel per cycle, index 0..NUM_CH-1. acc += enable[i] ? (sample[i]*vol[i]) >>> VOLUME_BITS : 0. After the last channel -> SCALE.
  - SCALE: m = (acc * master_volume) >>> VOLUME_BITS, then saturate to [-2^(SAMPLE_BITS-1), 2^(SAMPLE_BITS-1)-1] -> WRITE.
  - WRITE: wr_en=1 for exactly one cycle; update wr_addr, wr_data and clip together -> IDLE.
- Latency:
  - Tick at cycle T: ACCUM occupies T+1..T+NUM_CH, SCALE is T+NUM_CH+1, wr_en at T+NUM_CH+2.
  - busy is high from T+1 through the wr_en cycle inclusive.
- Arithmetic:
  - Product width SAMPLE_BITS+VOLUME_BITS+1, signed.
  - Accumulator width SAMPLE_BITS+$clog2(NUM_CH)+2, signed; it never overflows internally.
  - Shifts are arithmetic, i.e. truncation toward -inf (e.g. -1>>>8 = -1).
  - Volume 0 yields 0. Volume 2^VOLUME_BITS-1 is not unity: 8192*255>>>8 = 8160.
- clip: set if SCALE saturated; held with wr_data until the next write.
- Ticks while busy=1 (including the WRITE cycle): dropped, overrun=1 for that cycle, in-flight mix unaffected.
- refresh dropping mid-mix: current mix completes and writes; subsequent ticks are ignored. Ticks ignored for refresh=0 do not raise overrun.
- rst mid-mix: abort immediately; no wr_en is issued; everything returns to reset values next cycle.
- wr_addr/wr_data hold their values between writes.

Decomposition:
- Shared package audio_pkg holds:
  - mix_state_t enum {IDLE, ACCUM, SCALE, WRITE}
  - localparams for the product/accumulator width formulas
  - a pure saturate function (value, SAMPLE_BITS)
- Sub-module audio_vol_scale (combinational signed x unsigned multiply + arithmetic shift, parametrised widths).
  - One instance, muxed between channel data in ACCUM and acc/master in SCALE.
- Top module ~200 lines: snapshot registers, FSM, channel counter, accumulator.

Test Plan:
(defaults: NUM_CH=4, SAMPLE_BITS=16, VOLUME_BITS=8, BUF_LEN=256, LAG=1)
- Single channel scaling: ch0=16384, vol0=128, ch_enable=0001, master=255, rd_index=10, tick at T -> wr_en only at T+6, wr_addr=9, wr_data=8160, clip=0, busy high for T+1..T+6.
- Positive saturation: all channels 30000, vol 255, enable 1111, master 255 -> wr_data=32767, clip=1. Same with -30000 -> wr_data=-32768, clip=1.
- Negative truncation: ch0=-1, vol0=1, master=255, other channels disabled -> wr_data=16'hFFFF, clip=0. Then vol0=0 -> wr_data=0.
- Address wrap: rd_index=0 at tick -> wr_addr=255. Change rd_index to 50 at T+1 -> wr_addr still 255.
- Overrun and refresh:
  - Ticks at T and T+3 -> one wr_en at T+6, overrun pulse at T+3 only.
  - refresh=0 with tick -> no busy, no wr_en, no overrun.
- Reset mid-mix: rst asserted at T+2 -> no wr_en ever for that tick. All outputs 0 at T+3. Next tick after release mixes normally.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types, width helpers and saturation for the N-channel audio mixer.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    WRITE
  } mix_state_t;

  // A signed sample times an unsigned volume needs one extra bit so the
  // zero-extended volume can be treated as a signed operand.
  function automatic int prod_width(input int sample_bits, input int volume_bits);
    return sample_bits + volume_bits + 1;
  endfunction

  // Accumulator headroom: log2(channels) for the sum plus two guard bits,
  // enough that summing every scaled channel can never wrap.
  function automatic int acc_width(input int sample_bits, input int num_ch);
    return sample_bits + $clog2(num_ch) + 2;
  endfunction

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_SAMPLE_BITS = 16;
  localparam int DEF_VOLUME_BITS = 8;
  localparam int DEF_PROD_W      = prod_width(DEF_SAMPLE_BITS, DEF_VOLUME_BITS);
  localparam int DEF_ACC_W       = acc_width(DEF_SAMPLE_BITS, DEF_NUM_CH);

  // Clamp a wide signed value into the range of a signed word of 'bits' bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int bits);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (bits - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (bits - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/audio_vol_scale.sv
// Signed-by-unsigned gain stage: y = (a * b) >>> B_W, truncating toward -inf.
module audio_vol_scale
  import audio_pkg::*;
#(
  parameter int A_W = 19,
  parameter int B_W = 8
) (
  input  logic signed [A_W-1:0] a,
  input  logic        [B_W-1:0] b,
  output logic signed [A_W-1:0] y
);

  localparam int P_W = prod_width(A_W, B_W);

  logic signed [P_W-1:0] prod;

  // Multiply with the gain zero-extended into a signed operand, then drop the
  // fractional bits; the gain is below unity so the result always fits in A_W.
  always_comb begin
    prod = $signed(a) * $signed({1'b0, b});
    y    = A_W'(prod >>> B_W);
  end

endmodule

// File: rtl/audio_mix_nch.sv
// N-channel mixer: snapshots channels on a tick, sums per-channel scaled
// samples through one shared multiplier, applies master gain, saturates and
// writes one word into the playback ring buffer behind the read index.
module audio_mix_nch
  import audio_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SAMPLE_BITS = 16,
  parameter int VOLUME_BITS = 8,
  parameter int BUF_LEN     = 256,
  parameter int LAG         = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic                          refresh,
  input  logic [NUM_CH*SAMPLE_BITS-1:0] ch_sample,
  input  logic [NUM_CH*VOLUME_BITS-1:0] ch_volume,
  input  logic [NUM_CH-1:0]             ch_enable,
  input  logic [VOLUME_BITS-1:0]        master_volume,
  input  logic [$clog2(BUF_LEN)-1:0]    rd_index,
  output logic                          wr_en,
  output logic [$clog2(BUF_LEN)-1:0]    wr_addr,
  output logic [SAMPLE_BITS-1:0]        wr_data,
  output logic                          busy,
  output logic                          clip,
  output logic                          overrun
);

  localparam int AW    = $clog2(BUF_LEN);
  localparam int ACC_W = acc_width(SAMPLE_BITS, NUM_CH);
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [AW-1:0] LAG_A   = AW'(LAG);
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  mix_state_t state;
  mix_state_t state_next;

  logic signed [SAMPLE_BITS-1:0] samp_q [NUM_CH];
  logic        [VOLUME_BITS-1:0] vol_q  [NUM_CH];
  logic        [NUM_CH-1:0]      en_q;
  logic        [VOLUME_BITS-1:0] master_q;
  logic        [AW-1:0]          addr_q;
  logic        [CW-1:0]          ch_idx;
  logic signed [ACC_W-1:0]       acc;

  logic signed [ACC_W-1:0]       mul_a;
  logic        [VOLUME_BITS-1:0] mul_b;
  logic signed [ACC_W-1:0]       mul_y;
  logic signed [63:0]            scale_ext;
  logic signed [63:0]            sat_val;
  logic                          tick_ok;

  assign tick_ok = sample_tick && refresh && (state == IDLE);

  assign busy    = (state != IDLE);
  assign wr_en   = (state == WRITE) && !rst;
  assign overrun = sample_tick && refresh && busy && !rst;

  // Next-state logic: walk every channel once, then scale, then write.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick_ok) state_next = ACCUM;
      ACCUM:   if (ch_idx == LAST_CH) state_next = SCALE;
      SCALE:   state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Share the single multiplier: channel sample/volume while accumulating,
  // accumulator/master gain during the scale step.
  always_comb begin
    mul_a = ACC_W'(samp_q[ch_idx]);
    mul_b = vol_q[ch_idx];
    if (state == SCALE) begin
      mul_a = acc;
      mul_b = master_q;
    end
    scale_ext = 64'(mul_y);
    sat_val   = saturate(scale_ext, SAMPLE_BITS);
  end

  audio_vol_scale #(
    .A_W (ACC_W),
    .B_W (VOLUME_BITS)
  ) u_scale (
    .a (mul_a),
    .b (mul_b),
    .y (mul_y)
  );

  // State, snapshot, accumulator and output registers; reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      en_q     <= '0;
      master_q <= '0;
      addr_q   <= '0;
      ch_idx   <= '0;
      acc      <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      clip     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        samp_q[i] <= '0;
        vol_q[i]  <= '0;
      end
    end else begin
      state <= state_next;
      if (tick_ok) begin
        for (int i = 0; i < NUM_CH; i++) begin
          samp_q[i] <= ch_sample[i*SAMPLE_BITS +: SAMPLE_BITS];
          vol_q[i]  <= ch_volume[i*VOLUME_BITS +: VOLUME_BITS];
        end
        en_q     <= ch_enable;
        master_q <= master_volume;
        addr_q   <= rd_index - LAG_A;
        ch_idx   <= '0;
        acc      <= '0;
      end
      if (state == ACCUM) begin
        if (en_q[ch_idx]) begin
          acc <= acc + mul_y;
        end
        ch_idx <= ch_idx + 1'b1;
      end
      if (state == SCALE) begin
        wr_data <= SAMPLE_BITS'(sat_val);
        clip    <= (sat_val != scale_ext);
        wr_addr <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_audio_mix_nch.sv
// Directed self-checking bench for the N-channel audio mixer (default sizes).
module tb_audio_mix_nch;

  logic        clk;
  logic        rst;
  logic        sample_tick;
  logic        refresh;
  logic [63:0] ch_sample;
  logic [31:0] ch_volume;
  logic [3:0]  ch_enable;
  logic [7:0]  master_volume;
  logic [7:0]  rd_index;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        clip;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  audio_mix_nch dut (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .refresh       (refresh),
    .ch_sample     (ch_sample),
    .ch_volume     (ch_volume),
    .ch_enable     (ch_enable),
    .master_volume (master_volume),
    .rd_index      (rd_index),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .clip          (clip),
    .overrun       (overrun)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] samp, input logic [31:0] vol,
                               input logic [3:0] en, input logic [7:0] mv,
                               input logic [7:0] rdi);
    ch_sample     = samp;
    ch_volume     = vol;
    ch_enable     = en;
    master_volume = mv;
    rd_index      = rdi;
  endtask

  task automatic scrambleInputs();
    ch_sample     = ~ch_sample;
    ch_volume     = ~ch_volume;
    ch_enable     = ~ch_enable;
    master_volume = ~master_volume;
    rd_index      = 8'd50;
  endtask

  task automatic runMix(input string tag, input logic [63:0] samp, input logic [31:0] vol,
                        input logic [3:0] en, input logic [7:0] mv, input logic [7:0] rdi,
                        input logic [15:0] exp_data, input logic exp_clip,
                        input logic [7:0] exp_addr, input logic drop_refresh);
    @(posedge clk); #1;
    applyStimulus(samp, vol, en, mv, rdi);
    sample_tick = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        sample_tick = 1'b0;
        scrambleInputs();
      end
      if (k == 2 && drop_refresh) refresh = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_busy"}, 32'(busy), 32'(k <= 6));
      checkOutput({tag, "_wr_en"}, 32'(wr_en), 32'(k == 6));
      checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
      if (k == 6 || k == 8) begin
        checkOutput({tag, "_wr_data"}, 32'(wr_data), 32'(exp_data));
        checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 32'(exp_addr));
        checkOutput({tag, "_clip"}, 32'(clip), 32'(exp_clip));
      end
    end
    refresh = 1'b1;
  endtask

  initial begin
    rst         = 1'b1;
    sample_tick = 1'b0;
    refresh     = 1'b1;
    applyStimulus(64'd0, 32'd0, 4'd0, 8'd0, 8'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_clip", 32'(clip), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    runMix("single", {16'd0, 16'd0, 16'd1000, 16'd16384}, {8'd0, 8'd0, 8'd255, 8'd128},
           4'b0001, 8'd255, 8'd10, 16'd8160, 1'b0, 8'd9, 1'b0);
    runMix("pos_sat", {16'd30000, 16'd30000, 16'd30000, 16'd30000}, {4{8'd255}},
           4'b1111, 8'd255, 8'd100, 16'h7FFF, 1'b1, 8'd99, 1'b0);
    runMix("neg_sat", {4{-16'sd30000}}, {4{8'd255}},
           4'b1111, 8'd255, 8'd200, 16'h8000, 1'b1, 8'd199, 1'b0);
    runMix("neg_trunc", {16'd500, 16'd500, 16'd500, -16'sd1}, {8'd255, 8'd255, 8'd255, 8'd1},
           4'b0001, 8'd255, 8'd5, 16'hFFFF, 1'b0, 8'd4, 1'b0);
    runMix("vol0_wrap", {16'd0, 16'd0, 16'd0, -16'sd1}, {8'd0, 8'd0, 8'd0, 8'd0},
           4'b0001, 8'd255, 8'd0, 16'd0, 1'b0, 8'd255, 1'b0);
    runMix("mixed_drop", {16'd3000, 16'd500, -16'sd2000, 16'd1000}, {8'd64, 8'd255, 8'd100, 8'd200},
           4'b1011, 8'd128, 8'd77, 16'd374, 1'b0, 8'd76, 1'b1);

    @(posedge clk); #1;
    applyStimulus({16'd0, 16'd0, 16'd1000, 16'd16384}, {8'd0, 8'd0, 8'd255, 8'd128},
                  4'b0001, 8'd255, 8'd10);
    sample_tick = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      sample_tick = (k == 3);
      if (k == 1) scrambleInputs();
      @(negedge clk);
      checkOutput("ovr_overrun", 32'(overrun), 32'(k == 3));
      checkOutput("ovr_wr_en", 32'(wr_en), 32'(k == 6));
      checkOutput("ovr_busy", 32'(busy), 32'(k <= 6));
      if (k == 6) checkOutput("ovr_wr_data", 32'(wr_data), 32'd8160);
    end
    sample_tick = 1'b0;

    refresh = 1'b0;
    @(posedge clk); #1;
    applyStimulus({16'd3000, 16'd500, -16'sd2000, 16'd1000}, {8'd64, 8'd255, 8'd100, 8'd200},
                  4'b1011, 8'd128, 8'd77);
    sample_tick = 1'b1;
    @(negedge clk);
    checkOutput("noref_overrun0", 32'(overrun), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      sample_tick = 1'b0;
      @(negedge clk);
      checkOutput("noref_busy", 32'(busy), 32'd0);
      checkOutput("noref_wr_en", 32'(wr_en), 32'd0);
      checkOutput("noref_overrun", 32'(overrun), 32'd0);
    end
    checkOutput("noref_hold_data", 32'(wr_data), 32'd8160);
    checkOutput("noref_hold_addr", 32'(wr_addr), 32'd9);
    refresh = 1'b1;

    @(posedge clk); #1;
    applyStimulus({16'd30000, 16'd30000, 16'd30000, 16'd30000}, {4{8'd255}},
                  4'b1111, 8'd255, 8'd100);
    sample_tick = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) sample_tick = 1'b0;
      if (k == 2) rst = 1'b1;
      if (k == 3) rst = 1'b0;
      @(negedge clk);
      checkOutput("rstmid_wr_en", 32'(wr_en), 32'd0);
      checkOutput("rstmid_busy", 32'(busy), 32'(k <= 2));
      if (k == 3) begin
        checkOutput("rstmid_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rstmid_wr_data", 32'(wr_data), 32'd0);
        checkOutput("rstmid_clip", 32'(clip), 32'd0);
        checkOutput("rstmid_overrun", 32'(overrun), 32'd0);
      end
    end

    runMix("post_rst", {16'd0, 16'd0, 16'd1000, 16'd16384}, {8'd0, 8'd0, 8'd255, 8'd128},
           4'b0001, 8'd255, 8'd10, 16'd8160, 1'b0, 8'd9, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
